// File: rtl/setup_selector_pkg.sv
// setup_selector shared types and defaults.
// Optional auto-repeat is enabled by defining HOLD_REPEAT_EN.
package setup_selector_pkg;

    localparam int SETUP_W        = 2;
    localparam int DEB_CYCLES_DEF = 1000000;
    localparam int REPEAT_DLY_DEF = 50000000;
    localparam int REPEAT_PER_DEF = 12500000;

    typedef enum logic [1:0] {
        IDLE,
        HOLD_WAIT,
        REPEAT
    } rep_state_e;

    // One modulo-4 step of the select code in the requested direction.
    function automatic logic [SETUP_W-1:0] setup_step(
        input logic [SETUP_W-1:0] cur,
        input logic               up
    );
        return up ? cur + 1'b1 : cur - 1'b1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus counter debounce for one active-low key.
// lvl is the accepted level (1 = pressed); rise pulses for one cycle on press.
module key_debounce
    import setup_selector_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk_50m,
    input  logic rst_n,
    input  logic key_n,
    output logic lvl,
    output logic rise
);

    localparam int             CW      = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0]  CNT_END = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          lvl_q;
    logic          pressed;

    assign pressed = ~sync[1];
    assign rise    = lvl & ~lvl_q;

    // Bring the raw key into the clock domain; idle state is released.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], key_n};
        end
    end

    // Accept a new level only after DEB_CYCLES consecutive mismatching samples.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            lvl <= 1'b0;
        end else if (pressed == lvl) begin
            cnt <= '0;
        end else if (cnt == CNT_END) begin
            cnt <= '0;
            lvl <= pressed;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Delayed copy of the accepted level for press-edge detection.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            lvl_q <= 1'b0;
        end else begin
            lvl_q <= lvl;
        end
    end

endmodule

// File: rtl/setup_selector.sv
// Turns debounced UP/DOWN presses into a modulo-4 setup code with change pulse.
// Define HOLD_REPEAT_EN to add hold-to-auto-repeat on a single held key.
module setup_selector
    import setup_selector_pkg::*;
#(
    parameter int                 DEB_CYCLES = DEB_CYCLES_DEF,
    parameter logic [SETUP_W-1:0] SETUP_INIT = 2'b00,
    parameter int                 REPEAT_DLY = REPEAT_DLY_DEF,
    parameter int                 REPEAT_PER = REPEAT_PER_DEF
) (
    input  logic               clk_50m,
    input  logic               rst_n,
    input  logic               key_up_n,
    input  logic               key_dn_n,
    output logic [SETUP_W-1:0] setup,
    output logic               setup_chg,
    output logic               up_lvl,
    output logic               dn_lvl
);

    logic up_ev;
    logic dn_ev;
    logic inc;
    logic dec;

    if (DEB_CYCLES < 2 || REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_bad_param
        $error("setup_selector: illegal parameter value");
    end

    key_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_deb_up (
        .clk_50m(clk_50m),
        .rst_n  (rst_n),
        .key_n  (key_up_n),
        .lvl    (up_lvl),
        .rise   (up_ev)
    );

    key_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_deb_dn (
        .clk_50m(clk_50m),
        .rst_n  (rst_n),
        .key_n  (key_dn_n),
        .lvl    (dn_lvl),
        .rise   (dn_ev)
    );

`ifdef HOLD_REPEAT_EN
    localparam int TMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] DLY_END = TW'(REPEAT_DLY - 1);
    localparam logic [TW-1:0] PER_END = TW'(REPEAT_PER - 1);

    rep_state_e    state;
    logic [TW-1:0] timer;
    logic          hold_dn;
    logic          rep_up;
    logic          rep_dn;
    logic          held_lvl;
    logic [TW-1:0] t_end;

    assign held_lvl = hold_dn ? dn_lvl : up_lvl;
    assign t_end    = (state == HOLD_WAIT) ? DLY_END : PER_END;

    // Repeat FSM: wait out the hold delay, then emit periodic synthetic events.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            timer   <= '0;
            hold_dn <= 1'b0;
            rep_up  <= 1'b0;
            rep_dn  <= 1'b0;
        end else begin
            rep_up <= 1'b0;
            rep_dn <= 1'b0;
            case (state)
                IDLE: begin
                    if ((up_ev ^ dn_ev) && (up_lvl ^ dn_lvl)) begin
                        state   <= HOLD_WAIT;
                        timer   <= '0;
                        hold_dn <= dn_ev;
                    end
                end
                HOLD_WAIT, REPEAT: begin
                    if (!held_lvl || (up_lvl && dn_lvl)) begin
                        state <= IDLE;
                        timer <= '0;
                    end else if (timer == t_end) begin
                        state  <= REPEAT;
                        timer  <= '0;
                        rep_up <= ~hold_dn;
                        rep_dn <= hold_dn;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    timer <= '0;
                end
            endcase
        end
    end

    assign inc = up_ev | rep_up;
    assign dec = dn_ev | rep_dn;
`else
    assign inc = up_ev;
    assign dec = dn_ev;
`endif

    // Apply a single-direction event; opposing events cancel out.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            setup     <= SETUP_INIT;
            setup_chg <= 1'b0;
        end else begin
            setup_chg <= 1'b0;
            if (inc ^ dec) begin
                setup     <= setup_step(setup, inc);
                setup_chg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_setup_selector.sv
// Directed self-checking bench for setup_selector with DEB_CYCLES = 8.
// Default build only (HOLD_REPEAT_EN undefined).
module tb_setup_selector;

    localparam int DEB = 8;

    logic       clk_50m;
    logic       rst_n;
    logic       key_up_n;
    logic       key_dn_n;
    logic [1:0] setup;
    logic       setup_chg;
    logic       up_lvl;
    logic       dn_lvl;

    int total;
    int passed;
    int chg_cnt;

    setup_selector #(
        .DEB_CYCLES(DEB),
        .SETUP_INIT(2'b00),
        .REPEAT_DLY(20),
        .REPEAT_PER(5)
    ) dut (
        .clk_50m  (clk_50m),
        .rst_n    (rst_n),
        .key_up_n (key_up_n),
        .key_dn_n (key_dn_n),
        .setup    (setup),
        .setup_chg(setup_chg),
        .up_lvl   (up_lvl),
        .dn_lvl   (dn_lvl)
    );

    initial clk_50m = 1'b0;
    always #10 clk_50m = ~clk_50m;

    // Count change pulses mid-cycle, away from the active edge.
    always @(negedge clk_50m) begin
        if (setup_chg === 1'b1) chg_cnt++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    // Press a key cleanly, hold past the event, release, let it settle.
    task automatic press(input bit up, input int exp_setup, input string tag);
        int c0;
        c0 = chg_cnt;
        @(negedge clk_50m);
        if (up) key_up_n = 1'b0;
        else    key_dn_n = 1'b0;
        repeat (16) @(negedge clk_50m);
        key_up_n = 1'b1;
        key_dn_n = 1'b1;
        repeat (14) @(negedge clk_50m);
        chk({tag, "_pulses"}, chg_cnt - c0, 1);
        chk({tag, "_setup"}, int'(setup), exp_setup);
    endtask

    initial begin
        int c0;
        int bad_lvl;
        int lvl_diff;
        total    = 0;
        passed   = 0;
        chg_cnt  = 0;
        rst_n    = 1'b0;
        key_up_n = 1'b1;
        key_dn_n = 1'b1;

        repeat (3) @(negedge clk_50m);
        chk("rst_setup", int'(setup), 0);
        chk("rst_chg", int'(setup_chg), 0);
        chk("rst_up_lvl", int'(up_lvl), 0);
        chk("rst_dn_lvl", int'(dn_lvl), 0);

        // Latency: key low from the cycle before edge 1.
        @(negedge clk_50m);
        rst_n    = 1'b1;
        key_up_n = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk_50m);
            #1;
            chk($sformatf("lat_up_lvl_e%0d", e), int'(up_lvl), (e >= DEB + 2) ? 1 : 0);
            chk($sformatf("lat_setup_e%0d", e), int'(setup), (e >= DEB + 3) ? 1 : 0);
            chk($sformatf("lat_chg_e%0d", e), int'(setup_chg), (e == DEB + 3) ? 1 : 0);
        end
        c0 = chg_cnt;
        repeat (20) @(negedge clk_50m);
        chk("hold_no_pulse", chg_cnt - c0, 0);
        chk("hold_setup", int'(setup), 1);
        key_up_n = 1'b1;
        repeat (14) @(negedge clk_50m);
        chk("release_lvl", int'(up_lvl), 0);
        chk("release_setup", int'(setup), 1);

        // Back to 0, then wrap upward and downward.
        press(1'b0, 0, "dn_1to0");
        press(1'b1, 1, "up_0to1");
        press(1'b1, 2, "up_1to2");
        press(1'b1, 3, "up_2to3");
        press(1'b1, 0, "up_3to0");
        press(1'b0, 3, "dn_0to3");

        // Bounce: 3-cycle low pulses never reach the debounce threshold.
        c0      = chg_cnt;
        bad_lvl = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_50m);
            if (up_lvl !== 1'b0) bad_lvl++;
            key_up_n = ((i % 6) < 3) ? 1'b0 : 1'b1;
        end
        key_up_n = 1'b1;
        repeat (14) @(negedge clk_50m);
        chk("bounce_pulses", chg_cnt - c0, 0);
        chk("bounce_lvl_seen", bad_lvl, 0);
        chk("bounce_setup", int'(setup), 3);

        // Simultaneous press: both events cancel.
        c0       = chg_cnt;
        lvl_diff = 0;
        @(negedge clk_50m);
        key_up_n = 1'b0;
        key_dn_n = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_50m);
            if (up_lvl !== dn_lvl) lvl_diff++;
        end
        chk("sim_lvl_diff", lvl_diff, 0);
        chk("sim_up_lvl", int'(up_lvl), 1);
        chk("sim_dn_lvl", int'(dn_lvl), 1);
        chk("sim_pulses", chg_cnt - c0, 0);
        chk("sim_setup", int'(setup), 3);
        key_up_n = 1'b1;
        key_dn_n = 1'b1;
        repeat (14) @(negedge clk_50m);

        // Reach setup=2 with DOWN still held, then reset mid-hold.
        @(negedge clk_50m);
        key_dn_n = 1'b0;
        repeat (16) @(negedge clk_50m);
        chk("pre_rst_setup", int'(setup), 2);
        chk("pre_rst_dn_lvl", int'(dn_lvl), 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_setup", int'(setup), 0);
        chk("async_rst_dn_lvl", int'(dn_lvl), 0);
        repeat (2) @(posedge clk_50m);
        @(negedge clk_50m);
        rst_n = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk_50m);
            #1;
            chk($sformatf("rr_setup_e%0d", e), int'(setup), (e >= DEB + 3) ? 3 : 0);
            chk($sformatf("rr_chg_e%0d", e), int'(setup_chg), (e == DEB + 3) ? 1 : 0);
        end
        key_dn_n = 1'b1;
        repeat (4) @(negedge clk_50m);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
